fog_rate_integrator: RTL and testbench

- Sits directly downstream of the FOG closed-loop core and consumes its feedback step word (o_step) together with the step-sync pulse.
- Accumulates step samples into rate windows. A window closes either after 2^N samples (averaged) or on an external sync pulse (raw sum plus count).
- Also keeps a free-running angle integral.
- Window results are buffered in a small FIFO and read by the CPU/output stage through a valid/ready handshake.

---
 rtl/fog_rate_integrator.sv | 251 +++++++++++++++++++++++++
 tb/tb_fog_rate_integrator.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fog_rate_integrator.sv
// Rate/angle integrator for the FOG feedback step stream: windowed rate records
// (2^N average or externally synced sum) delivered through a small FIFO, plus a running angle.
module fog_rate_integrator #(
  parameter int DATA_W     = 32,
  parameter int ACC_W      = 48,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_step_vld,
  input  logic [DATA_W-1:0] i_step,
  input  logic              i_ext_mode,
  input  logic [4:0]        i_avg_shift,
  input  logic              i_sync,
  input  logic              i_angle_clr,
  input  logic              i_ovf_clr,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_rate,
  output logic [15:0]       o_cnt,
  output logic [ACC_W-1:0]  o_angle,
  output logic              o_ovf
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  // Signed DATA_W limits expressed at accumulator width.
  localparam logic [ACC_W-1:0] RATE_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] RATE_MIN = ~RATE_MAX;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_PUSH
  } state_t;

  typedef struct packed {
    logic [ACC_W-1:0] acc;
    logic [15:0]      cnt;
    logic [3:0]       shift;
    logic             ext;
  } close_rec_t;

  // ---------------------------------------------------------------------------
  // Window accumulator
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [3:0]       shift_q;
  logic             ext_q;

  logic             step_acc;
  logic [ACC_W-1:0] step_ext;
  logic [3:0]       live_shift;
  logic [3:0]       eff_shift;
  logic             eff_ext;
  logic [ACC_W-1:0] win_acc;
  logic [15:0]      win_cnt;
  logic             close;
  close_rec_t       close_rec;

  assign step_acc   = i_en & i_step_vld;
  assign step_ext   = {{(ACC_W-DATA_W){i_step[DATA_W-1]}}, i_step};
  assign live_shift = (i_avg_shift > 5'd15) ? 4'd15 : i_avg_shift[3:0];

  // An empty window still follows the live configuration; it freezes on the first sample.
  assign eff_shift  = (cnt_q == 16'd0) ? live_shift : shift_q;
  assign eff_ext    = (cnt_q == 16'd0) ? i_ext_mode : ext_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    win_acc = acc_q;
    win_cnt = cnt_q;
    if (step_acc) begin
      win_acc = acc_q + step_ext;
      win_cnt = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    end

    if (!i_en)
      close = 1'b0;
    else if (eff_ext)
      close = i_sync;
    else
      close = step_acc && (win_cnt == (16'd1 << eff_shift));

    acc_d = win_acc;
    cnt_d = win_cnt;
    if (!i_en || close) begin
      acc_d = '0;
      cnt_d = '0;
    end
  end

  assign close_rec = '{acc: win_acc, cnt: win_cnt, shift: eff_shift, ext: eff_ext};

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      ext_q   <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      if (cnt_q == 16'd0) begin
        shift_q <= live_shift;
        ext_q   <= i_ext_mode;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result pipeline: hold -> CALC -> PUSH, with a one-deep pending slot
  // ---------------------------------------------------------------------------
  state_t            state_q;
  close_rec_t        hold_q;
  close_rec_t        pend_q;
  logic              pend_vld_q;
  logic [DATA_W-1:0] rate_q;
  logic [15:0]       rcnt_q;

  logic              pend_take;
  logic              pend_drop;
  logic [ACC_W-1:0]  round_term;
  logic [ACC_W-1:0]  shifted;
  logic [ACC_W-1:0]  pre_sat;
  logic [DATA_W-1:0] calc_rate;

  assign pend_take = (state_q == ST_IDLE) && pend_vld_q;
  assign pend_drop = close && (state_q != ST_IDLE) && pend_vld_q;

  always_comb begin
    round_term = '0;
    if (hold_q.shift != 4'd0)
      round_term = {{(ACC_W-1){1'b0}}, 1'b1} << (hold_q.shift - 4'd1);
    shifted = $signed(hold_q.acc + round_term) >>> hold_q.shift;
    pre_sat = hold_q.ext ? hold_q.acc : shifted;

    if ($signed(pre_sat) > $signed(RATE_MAX))
      calc_rate = RATE_MAX[DATA_W-1:0];
    else if ($signed(pre_sat) < $signed(RATE_MIN))
      calc_rate = RATE_MIN[DATA_W-1:0];
    else
      calc_rate = pre_sat[DATA_W-1:0];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      rate_q     <= '0;
      rcnt_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pend_vld_q) begin
            hold_q  <= pend_q;
            state_q <= ST_CALC;
          end else if (close) begin
            hold_q  <= close_rec;
            state_q <= ST_CALC;
          end
        end
        ST_CALC: begin
          rate_q  <= calc_rate;
          rcnt_q  <= hold_q.cnt;
          state_q <= ST_PUSH;
        end
        ST_PUSH: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase

      // A close while busy parks in the pending slot; the slot frees as IDLE hands it to hold.
      if (close && (pend_take || (state_q != ST_IDLE && !pend_vld_q))) begin
        pend_q     <= close_rec;
        pend_vld_q <= 1'b1;
      end else if (pend_take) begin
        pend_vld_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] rate_mem [FIFO_DEPTH];
  logic [15:0]       cnt_mem  [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr_q, rd_ptr_q;

  logic fifo_full;
  logic push;
  logic push_ok;
  logic pop;
  logic fifo_drop;

  assign fifo_full = (wr_ptr_q - rd_ptr_q) == (PTR_W+1)'(FIFO_DEPTH);
  assign o_valid   = (wr_ptr_q != rd_ptr_q);
  assign pop       = o_valid & i_ready;
  assign push      = (state_q == ST_PUSH);
  assign push_ok   = push & (~fifo_full | pop);
  assign fifo_drop = push & fifo_full & ~pop;

  assign o_rate = o_valid ? rate_mem[rd_ptr_q[PTR_W-1:0]] : '0;
  assign o_cnt  = o_valid ? cnt_mem[rd_ptr_q[PTR_W-1:0]]  : '0;

  // NOTE: storage is not reset; pointers define which entries are live and outputs are gated by o_valid.
  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      rate_mem[wr_ptr_q[PTR_W-1:0]] <= rate_q;
      cnt_mem[wr_ptr_q[PTR_W-1:0]]  <= rcnt_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Angle integral and sticky overflow
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0] angle_q;
  logic             ovf_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      angle_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (i_angle_clr)
        angle_q <= '0;
      else if (step_acc)
        angle_q <= angle_q + step_ext;
      // A drop in the same cycle as a clear must leave the flag set.
      ovf_q <= (ovf_q & ~i_ovf_clr) | fifo_drop | pend_drop;
    end
  end

  assign o_angle = angle_q;
  assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_fog_rate_integrator.sv
// Directed self-checking bench for fog_rate_integrator; expected values are hand-computed.
module tb_fog_rate_integrator;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_en;
  logic        i_step_vld;
  logic [31:0] i_step;
  logic        i_ext_mode;
  logic [4:0]  i_avg_shift;
  logic        i_sync;
  logic        i_angle_clr;
  logic        i_ovf_clr;
  logic        i_ready;
  logic        o_valid;
  logic [31:0] o_rate;
  logic [15:0] o_cnt;
  logic [47:0] o_angle;
  logic        o_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  fog_rate_integrator #(.DATA_W(32), .ACC_W(48), .FIFO_DEPTH(4)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_en        (i_en),
    .i_step_vld  (i_step_vld),
    .i_step      (i_step),
    .i_ext_mode  (i_ext_mode),
    .i_avg_shift (i_avg_shift),
    .i_sync      (i_sync),
    .i_angle_clr (i_angle_clr),
    .i_ovf_clr   (i_ovf_clr),
    .i_ready     (i_ready),
    .o_valid     (o_valid),
    .o_rate      (o_rate),
    .o_cnt       (o_cnt),
    .o_angle     (o_angle),
    .o_ovf       (o_ovf)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
  endtask

  // Called at a negedge; the sample is taken on the following posedge.
  task automatic step(input logic [31:0] v);
    i_step_vld = 1'b1;
    i_step     = v;
    tick();
    i_step_vld = 1'b0;
  endtask

  task automatic sync_pulse();
    i_sync = 1'b1;
    tick();
    i_sync = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!o_valid && n < 10) begin
      tick();
      n++;
    end
    check(tag, 64'(o_valid), 64'(1));
  endtask

  task automatic pop_check(input string tag, input logic [31:0] rate, input logic [15:0] cnt);
    check({tag, "_rate"}, 64'(o_rate), 64'(rate));
    check({tag, "_cnt"}, 64'(o_cnt), 64'(cnt));
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; i_en = 1'b0; i_step_vld = 1'b0; i_step = '0;
    i_ext_mode = 1'b0; i_avg_shift = 5'd2; i_sync = 1'b0;
    i_angle_clr = 1'b0; i_ovf_clr = 1'b0; i_ready = 1'b0;
    tick(); tick();
    i_rst = 1'b0;
    tick();

    check("rst_valid", 64'(o_valid), 64'(0));
    check("rst_rate",  64'(o_rate),  64'(0));
    check("rst_cnt",   64'(o_cnt),   64'(0));
    check("rst_angle", 64'(o_angle), 64'(0));
    check("rst_ovf",   64'(o_ovf),   64'(0));

    // Internal N=2: (25+2)>>>2 = 6, valid two edges after the closing sample.
    i_en = 1'b1;
    step(32'd10); step(32'd11); step(32'hFFFF_FFFD); step(32'd7);
    check("t1_lat0", 64'(o_valid), 64'(0));
    tick();
    check("t1_lat1", 64'(o_valid), 64'(0));
    tick();
    check("t1_lat2", 64'(o_valid), 64'(1));
    check("t1_angle", 64'(o_angle), 64'(48'd25));
    tick();
    check("t1_hold", 64'(o_rate), 64'(32'd6));
    pop_check("t1", 32'd6, 16'd4);
    check("t1_empty", 64'(o_valid), 64'(0));

    // Internal N=1 with angle clear on the first sample: rate (-5+1)>>>1 = -2, angle = -2.
    i_avg_shift = 5'd1;
    i_angle_clr = 1'b1;
    step(32'hFFFF_FFFD);
    i_angle_clr = 1'b0;
    check("t2_angle_clr", 64'(o_angle), 64'(0));
    step(32'hFFFF_FFFE);
    check("t2_angle", 64'(o_angle), 64'(48'hFFFF_FFFF_FFFE));
    wait_valid("t2_wait");
    pop_check("t2", 32'hFFFF_FFFE, 16'd2);

    // External mode, sum saturates.
    i_ext_mode = 1'b1;
    step(32'h7FFF_FFFF); step(32'h7FFF_FFFF); step(32'h7FFF_FFFF);
    tick();
    sync_pulse();
    wait_valid("t3_wait");
    pop_check("t3", 32'h7FFF_FFFF, 16'd3);

    // Sync coincident with a sample, then an empty external window.
    step(32'd1); step(32'd2);
    i_sync = 1'b1;
    step(32'd5);
    i_sync = 1'b0;
    wait_valid("t4_wait");
    pop_check("t4", 32'd8, 16'd3);
    sync_pulse();
    wait_valid("t4e_wait");
    pop_check("t4e", 32'd0, 16'd0);

    // N=0 with the consumer stalled: four records fill the FIFO, two more are dropped.
    i_ext_mode = 1'b0;
    i_avg_shift = 5'd0;
    for (int k = 1; k <= 6; k++) begin
      step(32'(k));
      tick(); tick(); tick();
    end
    check("t5_ovf", 64'(o_ovf), 64'(1));
    for (int k = 1; k <= 4; k++)
      pop_check("t5_pop", 32'(k), 16'd1);
    check("t5_empty", 64'(o_valid), 64'(0));
    i_ovf_clr = 1'b1;
    tick();
    i_ovf_clr = 1'b0;
    check("t5_ovf_clr", 64'(o_ovf), 64'(0));

    // Back-to-back closes: hold, pending, then one dropped at the pending slot.
    step(32'd10); step(32'd20); step(32'd30);
    tick(); tick(); tick(); tick();
    check("t6_ovf", 64'(o_ovf), 64'(1));
    pop_check("t6_a", 32'd10, 16'd1);
    pop_check("t6_b", 32'd20, 16'd1);
    check("t6_empty", 64'(o_valid), 64'(0));
    i_ovf_clr = 1'b1;
    tick();
    i_ovf_clr = 1'b0;

    // Disabling mid-window discards the partial window: (4+2)>>>2 = 1.
    i_avg_shift = 5'd2;
    step(32'd3); step(32'd3);
    i_en = 1'b0;
    tick();
    i_en = 1'b1;
    step(32'd1); step(32'd1); step(32'd1); step(32'd1);
    wait_valid("t7_wait");
    pop_check("t7", 32'd1, 16'd4);

    // Reset mid-window with a record queued and the overflow flag set.
    i_avg_shift = 5'd0;
    step(32'd9);
    wait_valid("t8_pre");
    i_avg_shift = 5'd2;
    step(32'd1); step(32'd1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check("t8_valid", 64'(o_valid), 64'(0));
    check("t8_angle", 64'(o_angle), 64'(0));
    check("t8_ovf",   64'(o_ovf),   64'(0));
    step(32'd4); step(32'd4); step(32'd4); step(32'd5);
    wait_valid("t8_wait");
    pop_check("t8", 32'd4, 16'd4);
    check("t8_angle2", 64'(o_angle), 64'(48'd17));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
